rmii_frame_player: RTL
======================

Name: rmii_frame_player

Overview:
- Synthesizable RMII receive-side frame generator that plays a buffered byte frame onto RMII rx pins.
- Emits lead-in zero dibits, preamble/SFD, payload, optional appended FCS and an inter-frame gap.
- Used as on-chip stimulus and loopback source for the eth MAC receiver, arp_machine and udp_machine, in simulation and on hardware.
- Generalises fixed-frame driving with parametrised buffer depth, dibit rate, lead/gap lengths, CRC append, repeat count and error injection.

Parameters:
- AW, 11, buffer address width; depth 2**AW bytes.
- CLK_PER_DIBIT, 2, clk cycles each dibit is held (>=1).
- LEAD_DIBITS, 2, zero dibits with crs_dv high before the preamble.
- PRE_BYTES, 7, count of 0x55 bytes before the SFD (0xD5).
- GAP_BYTES, 12, idle byte-times after a frame, before the next repeat or done.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe; ignored while busy.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  buffer write data.
- start  in  1  single-cycle start; ignored while busy.
- len  in  AW+1  payload byte count, 0..2**AW; sampled at start.
- append_crc  in  1  append 4-byte Ethernet FCS; sampled at start.
- repeat_n  in  8  extra repetitions, so total frames = repeat_n+1; sampled at start.
- err_en  in  1  assert rx_err during one payload byte; sampled at start.
- err_idx  in  AW  payload byte index for the error; sampled at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final gap.
- frame_cnt  out  8  frames completed since the last start.
- eth_rxd  out  2  RMII data, LSB dibit first.
- eth_crs_dv  out  1  RMII carrier/data valid.
- eth_rx_err  out  1  RMII receive error.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts: outputs 0 on the next edge, no done pulse. Buffer contents are not cleared.
- Buffer: single-port RAM written when wr_en && !busy; read with 1-cycle latency, prefetched so dibit timing never stalls.
- States: IDLE -> LEAD -> PRE -> SFD -> DATA -> CRC (only if append_crc) -> GAP -> (repeat ? LEAD : IDLE).
- Accepted start (IDLE && start && len!=0): busy=1 and eth_crs_dv=1 with eth_rxd=0 on the next cycle; frame_cnt cleared.
- start with len==0: no RMII activity; done pulses one cycle later; busy stays 0.
- Dibit timing:
  - Every dibit holds exactly CLK_PER_DIBIT cycles.
  - Byte b goes out as b[1:0], b[3:2], b[5:4], b[7:6].
  - LEAD lasts LEAD_DIBITS dibits; PRE lasts PRE_BYTES bytes of 0x55; SFD is 0xD5.
  - DATA plays bytes 0..len-1 from the buffer.
- CRC:
  - Computed over payload bytes only: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per dibit during DATA.
  - FCS = ~crc, sent LSB byte first (bits [7:0] first).
- eth_crs_dv falls on the first cycle after the last dibit's hold ends; eth_rxd=0 whenever crs_dv=0.
- Error injection: eth_rx_err=1 for all 4 dibits of payload byte err_idx when err_en && err_idx<len; otherwise 0.
- GAP: GAP_BYTES*4*CLK_PER_DIBIT cycles with crs_dv=0. frame_cnt increments at the end of each GAP.
- Completion: after the last repeat, done=1 for one cycle and busy=0 in that same cycle. A start on the done cycle is ignored; a start on the following cycle is accepted.
- Frame cycle count (crs_dv high): (LEAD_DIBITS + 4*(PRE_BYTES+1+len+4*append_crc)) * CLK_PER_DIBIT.

Test Plan:
- Defaults; load A1 B2 C3 D4 E5, len=5, append_crc=1, start -> DUT eth MAC reports bytes A1 B2 C3 D4 E5 DF F9 C3 9A with rx_crc_ok=1; crs_dv high for (2+4*17)*2=140 cycles; done 96 cycles after crs_dv falls.
- Load the 64-byte ARP request for 192.168.2.5 (FCS included), append_crc=0 -> MAC rx_crc_ok=1; arp_machine asserts count_arp and starts a tx reply.
- Same ARP frame, repeat_n=2 -> three identical frames separated by exactly 96 idle cycles; frame_cnt steps 1,2,3; a single done pulse at the end.
- UDP frame to port 0x4E50, err_en=1, err_idx=44 -> eth_rx_err high for 8 cycles on byte 44; MAC flags rx_err; udp_machine produces no rx_udp_dvld.
- start while busy, wr_en while busy, and len=0 -> first two ignored and buffer unchanged; len=0 gives done 1 cycle later with no crs_dv.
- reset asserted mid-DATA -> eth_crs_dv=0 and busy=0 on the next edge, no done; a following start plays the full frame correctly.

Source files
------------

// File: rtl/rmii_frame_player.sv
// rmii_frame_player
//   Plays a frame held in an internal byte buffer onto the receive side of an
//   RMII interface. Each frame is: LEAD_DIBITS zero dibits with carrier up,
//   PRE_BYTES of 0x55, the SFD 0xD5, len payload bytes from the buffer, an
//   optional 4-byte Ethernet FCS, then an idle gap of GAP_BYTES byte-times.
//   The frame is repeated repeat_n extra times, then done pulses once.
//
//   LEAD_DIBITS, PRE_BYTES and GAP_BYTES are expected to be at least 1.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data buffer write port (ignored while busy)
//   start                 start pulse (ignored while busy or on the done cycle)
//   len                   payload length 0..2**AW, sampled at start
//   append_crc            append FCS, sampled at start
//   repeat_n              extra repetitions, sampled at start
//   err_en/err_idx        drive rx_err for one payload byte, sampled at start
//   busy, done            activity flag and completion pulse
//   frame_cnt             frames completed since the last start
//   eth_rxd/eth_crs_dv/eth_rx_err  RMII receive pins
module rmii_frame_player #(
  parameter int AW            = 11,
  parameter int CLK_PER_DIBIT = 2,
  parameter int LEAD_DIBITS   = 2,
  parameter int PRE_BYTES     = 7,
  parameter int GAP_BYTES     = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          append_crc,
  input  logic [7:0]    repeat_n,
  input  logic          err_en,
  input  logic [AW-1:0] err_idx,
  output logic          busy,
  output logic          done,
  output logic [7:0]    frame_cnt,
  output logic [1:0]    eth_rxd,
  output logic          eth_crs_dv,
  output logic          eth_rx_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int GAP_CYC = GAP_BYTES * 4 * CLK_PER_DIBIT;
  localparam int HW      = (CLK_PER_DIBIT > 1) ? $clog2(CLK_PER_DIBIT) : 1;
  // One shared counter indexes lead dibits, preamble bytes, payload bytes,
  // FCS bytes and gap cycles, so it must fit the largest of them.
  localparam int CW      = max2(AW + 1, max2($clog2(GAP_CYC + 1),
                                max2($clog2(LEAD_DIBITS + 1), $clog2(PRE_BYTES + 1))));

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_PRE, S_SFD, S_DATA, S_CRC, S_GAP, S_DONE
  } state_t;

  // Reflected CRC-32 advanced by one dibit, LSB first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      dib_q, dib_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic [23:0]     fcs_q, fcs_d;
  logic [31:0]     crc_q, crc_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            err_hit_q, err_hit_d;
  logic [AW:0]     len_q, len_d;
  logic            crc_en_q, crc_en_d;
  logic [7:0]      rep_q, rep_d;
  logic            err_en_q, err_en_d;
  logic [AW-1:0]   err_idx_q, err_idx_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;

  logic            busy_int;
  logic            crs_int;
  logic            dibit_end;
  logic            byte_end;
  logic [1:0]      cur_dibit;
  logic [31:0]     crc_new;
  logic [CW-1:0]   len_ext;
  logic            launch;
  logic            goto_gap;

  // Buffer: one address port, owned by the writer while idle and by the
  // player while busy (writes are blocked then, so nothing is lost).
  logic [7:0]      mem [0:(2**AW)-1];
  logic [7:0]      ram_rd_q;
  logic [AW-1:0]   ram_addr;

  assign ram_addr = busy_int ? rd_addr_q : wr_addr;

  always_ff @(posedge clk) begin
    if (wr_en && !busy_int) begin
      mem[ram_addr] <= wr_data;
    end
    ram_rd_q <= mem[ram_addr];
  end

  assign busy_int  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign crs_int   = (state_q == S_LEAD) || (state_q == S_PRE) || (state_q == S_SFD) ||
                     (state_q == S_DATA) || (state_q == S_CRC);
  assign dibit_end = (hold_q == HW'(CLK_PER_DIBIT - 1));
  assign byte_end  = dibit_end && (dib_q == 2'd3);
  assign len_ext   = CW'(len_q);
  assign crc_new   = crc_dibit(crc_q, cur_dibit);

  always_comb begin
    cur_dibit = 2'b00;
    case (dib_q)
      2'd0: cur_dibit = byte_q[1:0];
      2'd1: cur_dibit = byte_q[3:2];
      2'd2: cur_dibit = byte_q[5:4];
      default: cur_dibit = byte_q[7:6];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    dib_d       = dib_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    fcs_d       = fcs_q;
    crc_d       = crc_q;
    rd_addr_d   = rd_addr_q;
    err_hit_d   = err_hit_q;
    len_d       = len_q;
    crc_en_d    = crc_en_q;
    rep_d       = rep_q;
    err_en_d    = err_en_q;
    err_idx_d   = err_idx_q;
    frame_cnt_d = frame_cnt_q;
    launch      = 1'b0;
    goto_gap    = 1'b0;

    // Dibit pacing shared by every state that has the carrier up.
    if (crs_int) begin
      hold_d = dibit_end ? '0 : hold_q + 1'b1;
      if (dibit_end) begin
        dib_d = dib_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_cnt_d = '0;
          len_d       = len;
          crc_en_d    = append_crc;
          rep_d       = repeat_n;
          err_en_d    = err_en;
          err_idx_d   = err_idx;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            launch = 1'b1;
          end
        end
      end

      S_LEAD: begin
        if (dibit_end) begin
          if (cnt_q == CW'(LEAD_DIBITS - 1)) begin
            state_d = S_PRE;
            cnt_d   = '0;
            byte_d  = 8'h55;
            dib_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_PRE: begin
        if (byte_end) begin
          if (cnt_q == CW'(PRE_BYTES - 1)) begin
            state_d = S_SFD;
            cnt_d   = '0;
            byte_d  = 8'hD5;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_SFD: begin
        // Byte 0 has been sitting in the read register since the frame began.
        if (byte_end) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          byte_d    = ram_rd_q;
          rd_addr_d = rd_addr_q + 1'b1;
          err_hit_d = err_en_q && (err_idx_q == '0);
        end
      end

      S_DATA: begin
        if (dibit_end) begin
          crc_d = crc_new;
        end
        if (byte_end) begin
          if (cnt_q == len_ext - 1'b1) begin
            err_hit_d = 1'b0;
            if (crc_en_q) begin
              state_d = S_CRC;
              cnt_d   = '0;
              byte_d  = ~crc_new[7:0];
              fcs_d   = ~crc_new[31:8];
            end else begin
              goto_gap = 1'b1;
            end
          end else begin
            // The next byte was fetched at least four cycles ago; immediately
            // request the one after it.
            cnt_d     = cnt_q + 1'b1;
            byte_d    = ram_rd_q;
            rd_addr_d = rd_addr_q + 1'b1;
            err_hit_d = err_en_q && (CW'(err_idx_q) == cnt_q + 1'b1);
          end
        end
      end

      S_CRC: begin
        if (byte_end) begin
          if (cnt_q == CW'(3)) begin
            goto_gap = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            byte_d = fcs_q[7:0];
            fcs_d  = {8'h00, fcs_q[23:8]};
          end
        end
      end

      S_GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (rep_q != 8'd0) begin
            rep_d  = rep_q - 8'd1;
            launch = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (goto_gap) begin
      state_d = S_GAP;
      cnt_d   = '0;
      hold_d  = '0;
      dib_d   = 2'd0;
    end

    // Start of every frame: zero dibits with carrier, fresh CRC, and the
    // buffer read pointed at byte 0 so it is ready before the SFD ends.
    if (launch) begin
      state_d   = S_LEAD;
      cnt_d     = '0;
      hold_d    = '0;
      dib_d     = 2'd0;
      byte_d    = 8'h00;
      crc_d     = 32'hFFFF_FFFF;
      rd_addr_d = '0;
      err_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      dib_q       <= '0;
      cnt_q       <= '0;
      byte_q      <= '0;
      fcs_q       <= '0;
      crc_q       <= '0;
      rd_addr_q   <= '0;
      err_hit_q   <= 1'b0;
      len_q       <= '0;
      crc_en_q    <= 1'b0;
      rep_q       <= '0;
      err_en_q    <= 1'b0;
      err_idx_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      dib_q       <= dib_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      fcs_q       <= fcs_d;
      crc_q       <= crc_d;
      rd_addr_q   <= rd_addr_d;
      err_hit_q   <= err_hit_d;
      len_q       <= len_d;
      crc_en_q    <= crc_en_d;
      rep_q       <= rep_d;
      err_en_q    <= err_en_d;
      err_idx_q   <= err_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign busy       = busy_int;
  assign done       = (state_q == S_DONE);
  assign frame_cnt  = frame_cnt_q;
  assign eth_crs_dv = crs_int;
  assign eth_rxd    = crs_int ? cur_dibit : 2'b00;
  assign eth_rx_err = (state_q == S_DATA) && err_hit_q;

endmodule
